// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED scan decoder: operating modes and scan direction.
package led_ctrl_pkg;

   localparam logic [1:0] MODE_MANUAL   = 2'b00;
   localparam logic [1:0] MODE_UP       = 2'b01;
   localparam logic [1:0] MODE_DOWN     = 2'b10;
   localparam logic [1:0] MODE_PINGPONG = 2'b11;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/led_scan_decoder_sw_debounce.sv
// Switch conditioner: 2-flop synchroniser plus stable-run counter; a new value is accepted
// after DB_CYCLES consecutive cycles of disagreement (latency 2 + DB_CYCLES clk), no backpressure.
module sw_debounce #(
   parameter int W         = 3,
   parameter int DB_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] sw_i,
   output logic [W-1:0] sw_db_o
);

   localparam int            CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [W-1:0]  s1_q, s2_q;
   logic [W-1:0]  db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter is not cleared when the synced value changes to another non-matching value.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= '1;
         s2_q  <= '1;
         db_q  <= '1;
         cnt_q <= '0;
      end else begin
         s1_q  <= sw_i;
         s2_q  <= s1_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign sw_db_o = db_q;

endmodule

// File: rtl/led_scan_decoder.sv
// Active-low one-hot LED driver: index from debounced switches or a prescaled up/down/ping-pong
// scanner; led follows idx by one clk, scan tick -> led in 2 clk, no backpressure.
module led_scan_decoder
   import led_ctrl_pkg::*;
#(
   parameter int SEL_W       = 3,
   parameter int DB_CYCLES   = 250000,
   parameter int STEP_CYCLES = 6000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEL_W-1:0]      sw,
   input  logic [1:0]            mode,
   input  logic                  en,
   output logic [(1<<SEL_W)-1:0] led,
   output logic [SEL_W-1:0]      idx,
   output logic                  step_pulse
);

   localparam int               N        = 1 << SEL_W;
   localparam int               PW       = $clog2(STEP_CYCLES);
   localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_CYCLES - 1);
   localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0] IDX_LAST = '1;
   localparam logic [N-1:0]     LED_ONE  = {{(N-1){1'b0}}, 1'b1};

   logic [SEL_W-1:0] sw_db;
   logic [1:0]       mode_s1_q, mode_s2_q, mode_prev_q;
   logic             en_s1_q, en_s2_q;
   logic [PW-1:0]    pre_q, pre_d;
   dir_t             dir_q, dir_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [N-1:0]     led_q, led_d;
   logic             step_q;
   logic             mode_chg, scan_act, tick;

   sw_debounce #(
      .W         (SEL_W),
      .DB_CYCLES (DB_CYCLES)
   ) u_sw_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_i    (sw),
      .sw_db_o (sw_db)
   );

   // A mode change restarts the step period, so a tick landing on that cycle is dropped.
   assign mode_chg = (mode_s2_q != mode_prev_q);
   assign scan_act = en_s2_q && (mode_s2_q != MODE_MANUAL);
   assign tick     = scan_act && !mode_chg && (pre_q == PRE_LAST);
   assign pre_d    = (!scan_act || mode_chg || tick) ? '0 : pre_q + PW'(1);

   always_comb begin
      idx_d = idx_q;
      dir_d = dir_q;
      if (mode_s2_q == MODE_MANUAL) begin
         idx_d = ~sw_db;
      end else if (mode_chg) begin
         if (mode_s2_q == MODE_PINGPONG) dir_d = DIR_UP;
      end else if (tick) begin
         case (mode_s2_q)
            MODE_UP:   idx_d = idx_q + IDX_ONE;
            MODE_DOWN: idx_d = idx_q - IDX_ONE;
            default: begin
               if (dir_q == DIR_UP) begin
                  if (idx_q == IDX_LAST) begin
                     idx_d = idx_q - IDX_ONE;
                     dir_d = DIR_DOWN;
                  end else begin
                     idx_d = idx_q + IDX_ONE;
                  end
               end else begin
                  if (idx_q == '0) begin
                     idx_d = IDX_ONE;
                     dir_d = DIR_UP;
                  end else begin
                     idx_d = idx_q - IDX_ONE;
                  end
               end
            end
         endcase
      end
   end

   // ~idx_q equals N-1-idx for a power-of-two LED count.
   assign led_d = en_s2_q ? ~(LED_ONE << ~idx_q) : '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1_q   <= MODE_MANUAL;
         mode_s2_q   <= MODE_MANUAL;
         mode_prev_q <= MODE_MANUAL;
         en_s1_q     <= 1'b0;
         en_s2_q     <= 1'b0;
         pre_q       <= '0;
         dir_q       <= DIR_UP;
         idx_q       <= '0;
         led_q       <= '1;
         step_q      <= 1'b0;
      end else begin
         mode_s1_q   <= mode;
         mode_s2_q   <= mode_s1_q;
         mode_prev_q <= mode_s2_q;
         en_s1_q     <= en;
         en_s2_q     <= en_s1_q;
         pre_q       <= pre_d;
         dir_q       <= dir_d;
         idx_q       <= idx_d;
         led_q       <= led_d;
         step_q      <= tick;
      end
   end

   assign led        = led_q;
   assign idx        = idx_q;
   assign step_pulse = step_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Bench for led_scan_decoder at SEL_W=3, DB_CYCLES=4, STEP_CYCLES=5: directed scenarios
// followed by randomized pin activity checked against a behavioural model.
module tb_led_scan_decoder;

   localparam int SEL_W = 3;
   localparam int DB    = 4;
   localparam int STEP  = 5;
   localparam int N     = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] sw;
   logic [1:0] mode;
   logic       en;
   logic [7:0] led;
   logic [2:0] idx;
   logic       step_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_scan_decoder #(
      .SEL_W       (SEL_W),
      .DB_CYCLES   (DB),
      .STEP_CYCLES (STEP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw         (sw),
      .mode       (mode),
      .en         (en),
      .led        (led),
      .idx        (idx),
      .step_pulse (step_pulse)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Index i lights led[N-1-i], active low.
   function automatic logic [7:0] led_of(input int i);
      logic [7:0] top;
      top = 8'h80;
      return ~(top >> i);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; sw = 3'b111; mode = 2'b01; en = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(30);
      checks++;
      if (idx !== 3'd5) begin errors++; $display("FAIL pre_reset_idx got %0d want 5", idx); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 8'hFF) begin errors++; $display("FAIL async_reset_led got %h want ff", led); end
      checks++;
      if (idx !== 3'd0) begin errors++; $display("FAIL async_reset_idx got %0d want 0", idx); end
      checks++;
      if (step_pulse !== 1'b0) begin errors++; $display("FAIL async_reset_step got %b want 0", step_pulse); end
      mode = 2'b00;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      checks++;
      if (led !== 8'hFF) begin errors++; $display("FAIL release_led_e1 got %h want ff", led); end
      cyc(2);
      checks++;
      if (led !== 8'h7F) begin errors++; $display("FAIL release_led_e3 got %h want 7f", led); end
      checks++;
      if (idx !== 3'd0) begin errors++; $display("FAIL release_idx got %0d want 0", idx); end
   endtask

   task automatic test_manual_debounce();
      sw = 3'b101;
      cyc(6);
      checks++;
      if (idx !== 3'd0) begin errors++; $display("FAIL db_idx_early got %0d want 0", idx); end
      cyc(1);
      checks++;
      if (idx !== 3'd2 || led !== 8'h7F) begin
         errors++; $display("FAIL db_idx_c7 got idx %0d led %h want idx 2 led 7f", idx, led);
      end
      cyc(1);
      checks++;
      if (led !== 8'hDF) begin errors++; $display("FAIL db_led_c8 got %h want df", led); end
      sw = 3'b000;
      cyc(3);
      sw = 3'b101;
      for (int c = 0; c < 12; c++) begin
         cyc(1);
         checks++;
         if (idx !== 3'd2 || led !== 8'hDF) begin
            errors++; $display("FAIL glitch_c%0d got idx %0d led %h want idx 2 led df", c, idx, led);
         end
      end
   endtask

   task automatic test_scan_up();
      int prev;
      int exp_i;
      sw = 3'b111;
      cyc(10);
      checks++;
      if (idx !== 3'd0) begin errors++; $display("FAIL up_setup_idx got %0d want 0", idx); end
      mode = 2'b01;
      cyc(3);
      prev = 0;
      for (int s = 1; s <= 8; s++) begin
         for (int c = 1; c <= 5; c++) begin
            cyc(1);
            exp_i = (c == 5) ? s % N : s - 1;
            checks++;
            if (idx !== 3'(exp_i) || step_pulse !== (c == 5) || led !== led_of(prev)) begin
               errors++;
               $display("FAIL up_s%0d_c%0d got idx %0d step %b led %h want idx %0d step %b led %h",
                        s, c, idx, step_pulse, led, exp_i, (c == 5), led_of(prev));
            end
            prev = exp_i;
         end
      end
   endtask

   task automatic test_pingpong();
      int exp_seq[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
      int prev;
      int exp_i;
      mode = 2'b00;
      sw = 3'b001;
      cyc(12);
      checks++;
      if (idx !== 3'd6) begin errors++; $display("FAIL pp_setup_idx got %0d want 6", idx); end
      mode = 2'b11;
      cyc(3);
      prev = 6;
      for (int s = 0; s < 10; s++) begin
         for (int c = 1; c <= 5; c++) begin
            cyc(1);
            exp_i = (c == 5) ? exp_seq[s] : prev;
            checks++;
            if (idx !== 3'(exp_i) || step_pulse !== (c == 5)) begin
               errors++;
               $display("FAIL pp_s%0d_c%0d got idx %0d step %b want idx %0d step %b",
                        s, c, idx, step_pulse, exp_i, (c == 5));
            end
            prev = exp_i;
         end
      end
   endtask

   task automatic wait_idx(input logic [2:0] target, input string name);
      int n;
      n = 0;
      while (idx !== target && n < 60) begin
         cyc(1);
         n++;
      end
      checks++;
      if (idx !== target) begin
         errors++; $display("FAIL %s_timeout got idx %0d want %0d", name, idx, target);
      end
   endtask

   task automatic test_enable_mode();
      mode = 2'b01;
      cyc(3);
      wait_idx(3'd4, "en_wait");
      en = 1'b0;
      cyc(2);
      checks++;
      if (led !== led_of(4)) begin errors++; $display("FAIL en_led_c2 got %h want %h", led, led_of(4)); end
      cyc(1);
      checks++;
      if (led !== 8'hFF) begin errors++; $display("FAIL en_blank_c3 got %h want ff", led); end
      for (int c = 0; c < 10; c++) begin
         cyc(1);
         checks++;
         if (idx !== 3'd4 || step_pulse !== 1'b0 || led !== 8'hFF) begin
            errors++; $display("FAIL en_frozen_c%0d got idx %0d step %b led %h want idx 4 step 0 led ff",
                               c, idx, step_pulse, led);
         end
      end
      en = 1'b1;
      cyc(3);
      checks++;
      if (led !== led_of(4)) begin errors++; $display("FAIL en_resume_led got %h want %h", led, led_of(4)); end
      cyc(3);
      checks++;
      if (idx !== 3'd4) begin errors++; $display("FAIL en_resume_early got %0d want 4", idx); end
      cyc(1);
      checks++;
      if (idx !== 3'd5 || step_pulse !== 1'b1) begin
         errors++; $display("FAIL en_resume_step got idx %0d step %b want idx 5 step 1", idx, step_pulse);
      end
      wait_idx(3'd3, "mode_wait");
      mode = 2'b10;
      for (int c = 1; c <= 7; c++) begin
         cyc(1);
         checks++;
         if (idx !== 3'd3 || step_pulse !== 1'b0) begin
            errors++; $display("FAIL chg_hold_c%0d got idx %0d step %b want idx 3 step 0", c, idx, step_pulse);
         end
      end
      cyc(1);
      checks++;
      if (idx !== 3'd2 || step_pulse !== 1'b1) begin
         errors++; $display("FAIL chg_step got idx %0d step %b want idx 2 step 1", idx, step_pulse);
      end
   endtask

   // Model: synchronisers as 2-deep delay lines, debounce as a disagreement run length,
   // step timing as a run of active cycles, ping-pong as a phase on a 2N-2 cycle.
   task automatic test_random();
      logic [2:0] p1_sw, p2_sw, db, m_idx, ssw;
      logic [1:0] p1_m, p2_m, m_prev, sm;
      logic       p1_en, p2_en, se, m_sp, chg, act, tk;
      logic [7:0] m_led;
      int         diff_run, run, phase, sw_hold;

      #2 rst_n = 1'b0;
      sw = 3'b111; mode = 2'b00; en = 1'b1;
      p1_sw = 3'b111; p2_sw = 3'b111; db = 3'b111;
      p1_m = 2'b00; p2_m = 2'b00; m_prev = 2'b00;
      p1_en = 1'b0; p2_en = 1'b0;
      m_idx = 3'd0; m_led = 8'hFF; m_sp = 1'b0;
      diff_run = 0; run = 0; phase = 0; sw_hold = 0;
      cyc(2);
      rst_n = 1'b1;
      for (int t = 0; t < 3000; t++) begin
         checks++;
         if (idx !== m_idx || led !== m_led || step_pulse !== m_sp) begin
            errors++;
            $display("FAIL rand_t%0d got idx %0d led %h step %b want idx %0d led %h step %b",
                     t, idx, led, step_pulse, m_idx, m_led, m_sp);
         end
         if (sw_hold == 0) begin
            sw = 3'($urandom);
            sw_hold = $urandom_range(1, 9);
         end else begin
            sw_hold--;
         end
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 59) == 0) en = ($urandom_range(0, 3) != 0);

         ssw = p2_sw; sm = p2_m; se = p2_en;
         m_led = se ? led_of(int'(m_idx)) : 8'hFF;
         chg = (sm != m_prev);
         act = se && (sm != 2'b00);
         tk  = act && !chg && (run % STEP == STEP - 1);
         run = (act && !chg) ? run + 1 : 0;
         if (sm == 2'b00) begin
            m_idx = ~db;
         end else if (chg) begin
            if (sm == 2'b11) phase = int'(m_idx);
         end else if (tk) begin
            if (sm == 2'b01) m_idx = 3'((int'(m_idx) + 1) % N);
            else if (sm == 2'b10) m_idx = 3'((int'(m_idx) + N - 1) % N);
            else begin
               phase = (phase + 1) % (2 * N - 2);
               m_idx = 3'((phase < N) ? phase : 2 * N - 2 - phase);
            end
         end
         m_sp = tk;
         m_prev = sm;
         if (ssw != db) begin
            diff_run++;
            if (diff_run == DB) begin
               db = ssw;
               diff_run = 0;
            end
         end else begin
            diff_run = 0;
         end
         p2_sw = p1_sw; p1_sw = sw;
         p2_m  = p1_m;  p1_m  = mode;
         p2_en = p1_en; p1_en = en;
         cyc(1);
      end
   endtask

   initial begin
      test_reset();
      test_manual_debounce();
      test_scan_up();
      test_pingpong();
      test_enable_mode();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
